// File: rtl/bus_pkg.sv
// Shared definitions for the serial slave.
// Holds the FSM state encoding, the control-frame field widths and the rdWr encoding.
package bus_pkg;

    // FSM state encoding
    typedef logic [2:0] state_t;

    localparam state_t StIdle     = 3'd0;
    localparam state_t StRxCtrl   = 3'd1;
    localparam state_t StWrite    = 3'd2;
    localparam state_t StReadLoad = 3'd3;
    localparam state_t StReadTx   = 3'd4;

    // Control frame layout after START: id | rdWr | burst | address
    localparam int unsigned ID_W     = 2;
    localparam int unsigned RDWR_W   = 1;
    localparam int unsigned BURST_W  = 1;
    localparam int unsigned HDR_BITS = ID_W + RDWR_W + BURST_W;

    // rdWr encoding
    localparam logic [RDWR_W-1:0] RD_WR_WRITE = 1'b0;
    localparam logic [RDWR_W-1:0] RD_WR_READ  = 1'b1;

endpackage

// File: rtl/slave_mem.sv
// Single-port synchronous RAM, DEPTH x WIDTH, one-cycle read latency.
// Ports:
//   clk_i   - clock
//   en_i    - access enable
//   we_i    - write enable (write when en_i & we_i, read when en_i & ~we_i)
//   addr_i  - word address
//   wdata_i - write data
//   rdata_o - registered read data; holds its value when not reading
module slave_mem #(
    parameter int unsigned DEPTH  = 4096,
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                mem[addr_i] <= wdata_i;
            end else begin
                rdata_q <= mem[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/slave.sv
// Serial bus slave with an internal word memory.
// A control frame (START | id | rdWr | burst | address, MSB first) selects a write or
// read transfer; data moves one bit per cycle, MSB first, with optional bursts.
// Ports:
//   clk     - clock, rising edge
//   rst     - asynchronous active-high reset
//   control - serial control frame from master
//   wrD     - serial write data, qualified by valid
//   valid   - write-bit qualifier
//   last    - end-of-burst flag
//   rD      - serial read data (0 outside a read data phase)
//   ready   - high while accepting write bits or presenting read bits
module slave
    import bus_pkg::*;
#(
    parameter int unsigned MEMORY_DEPTH = 4096,
    parameter int unsigned DATA_WIDTH   = 16,
    parameter logic [1:0]  SLAVE_ID     = 2'b01
) (
    input  logic clk,
    input  logic rst,
    input  logic control,
    input  logic wrD,
    input  logic valid,
    input  logic last,
    output logic rD,
    output logic ready
);

    localparam int unsigned ADDRESS_WIDTH = $clog2(MEMORY_DEPTH);
    // Frame bits following the START bit
    localparam int unsigned CTRL_BITS     = HDR_BITS + ADDRESS_WIDTH;
    localparam int unsigned CNT_MAX       = (CTRL_BITS > DATA_WIDTH) ? CTRL_BITS : DATA_WIDTH;
    localparam int unsigned CNT_W         = $clog2(CNT_MAX);

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [CTRL_BITS-2:0]     ctrl_sr_q, ctrl_sr_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic                     burst_q, burst_d;
    logic [DATA_WIDTH-2:0]    wr_sr_q, wr_sr_d;
    logic [DATA_WIDTH-1:0]    tx_q, tx_d;
    logic                     last_q, last_d;

    logic                     mem_en, mem_we;
    logic [ADDRESS_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0]    mem_wdata, mem_rdata;

    // Full frame as it stands once the current control bit is included
    logic [CTRL_BITS-1:0]     frame;
    logic [ID_W-1:0]          frame_id;
    logic [RDWR_W-1:0]        frame_rdwr;
    logic                     frame_burst;
    logic [ADDRESS_WIDTH-1:0] frame_addr;
    logic [ADDRESS_WIDTH-1:0] addr_inc;

    assign frame       = {ctrl_sr_q, control};
    assign frame_id    = frame[CTRL_BITS-1 -: ID_W];
    assign frame_rdwr  = frame[CTRL_BITS-1-ID_W -: RDWR_W];
    assign frame_burst = frame[CTRL_BITS-1-ID_W-RDWR_W];
    assign frame_addr  = frame[ADDRESS_WIDTH-1:0];

    // Explicit wrap so non-power-of-two depths also roll over to zero
    assign addr_inc = (addr_q == ADDRESS_WIDTH'(MEMORY_DEPTH - 1)) ?
                      '0 : addr_q + ADDRESS_WIDTH'(1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ctrl_sr_d = ctrl_sr_q;
        addr_d    = addr_q;
        burst_d   = burst_q;
        wr_sr_d   = wr_sr_q;
        tx_d      = tx_q;
        last_d    = last_q;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = addr_q;
        mem_wdata = {wr_sr_q, wrD};

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (control) begin
                    state_d = StRxCtrl;
                end
            end

            StRxCtrl: begin
                ctrl_sr_d = {ctrl_sr_q[CTRL_BITS-3:0], control};
                cnt_d     = cnt_q + CNT_W'(1);
                // Read speculatively on every frame bit: on the final bit the address is
                // complete, so the word is already in the RAM output during READ_LOAD.
                mem_en    = 1'b1;
                mem_addr  = frame_addr;
                if (cnt_q == CNT_W'(CTRL_BITS - 1)) begin
                    cnt_d   = '0;
                    addr_d  = frame_addr;
                    burst_d = frame_burst;
                    last_d  = 1'b0;
                    if (frame_id != SLAVE_ID) begin
                        state_d = StIdle;
                    end else begin
                        unique case (frame_rdwr)
                            RD_WR_WRITE: state_d = StWrite;
                            RD_WR_READ:  state_d = StReadLoad;
                            default:     state_d = StIdle;
                        endcase
                    end
                end
            end

            StWrite: begin
                if (valid) begin
                    wr_sr_d = {wr_sr_q[DATA_WIDTH-3:0], wrD};
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                        mem_en = 1'b1;
                        mem_we = 1'b1;
                        cnt_d  = '0;
                        if (!burst_q || last) begin
                            state_d = StIdle;
                        end else begin
                            addr_d = addr_inc;
                        end
                    end
                end
            end

            StReadLoad: begin
                tx_d    = mem_rdata;
                cnt_d   = '0;
                state_d = StReadTx;
            end

            StReadTx: begin
                tx_d     = {tx_q[DATA_WIDTH-2:0], 1'b0};
                cnt_d    = cnt_q + CNT_W'(1);
                last_d   = last_q | last;
                // Prefetch the next burst word so it can load with no gap.
                mem_en   = 1'b1;
                mem_addr = addr_inc;
                if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                    cnt_d  = '0;
                    last_d = 1'b0;
                    if (!burst_q || last_q || last) begin
                        state_d = StIdle;
                    end else begin
                        addr_d = addr_inc;
                        tx_d   = mem_rdata;
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        ready = (state_q == StWrite) || (state_q == StReadTx);
        rD    = (state_q == StReadTx) ? tx_q[DATA_WIDTH-1] : 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            ctrl_sr_q <= '0;
            addr_q    <= '0;
            burst_q   <= 1'b0;
            wr_sr_q   <= '0;
            tx_q      <= '0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ctrl_sr_q <= ctrl_sr_d;
            addr_q    <= addr_d;
            burst_q   <= burst_d;
            wr_sr_q   <= wr_sr_d;
            tx_q      <= tx_d;
            last_q    <= last_d;
        end
    end

    slave_mem #(
        .DEPTH  (MEMORY_DEPTH),
        .WIDTH  (DATA_WIDTH),
        .ADDR_W (ADDRESS_WIDTH)
    ) u_mem (
        .clk_i   (clk),
        .en_i    (mem_en),
        .we_i    (mem_we),
        .addr_i  (mem_addr),
        .wdata_i (mem_wdata),
        .rdata_o (mem_rdata)
    );

endmodule

// File: tb/tb_slave.sv
// Self-checking bench for slave: directed transfers plus randomized write/read-back
// pairs. Expected read words are queued when a read is issued and a monitor compares
// them as the serial data comes out.
module tb_slave;

    localparam int DEPTH = 4096;
    localparam logic [1:0] SID = 2'b01;

    logic clk;
    logic rst;
    logic control;
    logic wrD;
    logic valid;
    logic last;
    logic rD;
    logic ready;

    int checks;
    int failures;

    // Reference memory: address -> word, only written locations are ever read back
    logic [15:0] model_mem [int];
    logic [15:0] sb_q [$];

    bit          rd_active;
    bit          mon_ignore;
    logic [15:0] mon_word;
    int          mon_nb;

    int          r_addr;
    int          r_k;
    bit          r_burst;
    logic [15:0] r_words [$];

    slave #(
        .MEMORY_DEPTH (DEPTH),
        .DATA_WIDTH   (16),
        .SLAVE_ID     (SID)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .control (control),
        .wrD     (wrD),
        .valid   (valid),
        .last    (last),
        .rD      (rD),
        .ready   (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: assembles read words while the slave presents them and scores them.
    initial begin
        mon_nb = 0;
        mon_word = '0;
        forever begin
            @(negedge clk);
            if (rst || mon_ignore) begin
                mon_nb = 0;
            end else if (rd_active && ready) begin
                mon_word = {mon_word[14:0], rD};
                mon_nb++;
                if (mon_nb == 16) begin
                    mon_nb = 0;
                    if (sb_q.size() == 0) begin
                        check("rd_unexpected_word", 32'(mon_word), 32'hFFFF_FFFF);
                    end else begin
                        check("rd_data", 32'(mon_word), 32'(sb_q.pop_front()));
                    end
                end
            end else begin
                check("rd_zero_outside_tx", 32'(rD), 32'd0);
            end
        end
    end

    task automatic send_frame(input logic [1:0] id, input bit rdwr, input bit burst,
                              input int addr);
        logic [15:0] f;
        f = {id, rdwr, burst, 12'(addr)};
        @(negedge clk);
        control = 1'b1;
        for (int i = 15; i >= 0; i--) begin
            @(negedge clk);
            control = f[i];
        end
        @(negedge clk);
        control = 1'b0;
    endtask

    // Drives one word MSB first; a 5-cycle valid=0 gap (with control noise) precedes
    // bit pause_at when pause_at >= 0.
    task automatic write_word(input logic [15:0] d, input bit is_last, input int pause_at,
                              input bit exp_rdy);
        for (int i = 15; i >= 0; i--) begin
            if (i == pause_at) begin
                for (int p = 0; p < 5; p++) begin
                    @(negedge clk);
                    valid   = 1'b0;
                    wrD     = 1'($urandom);
                    last    = 1'b0;
                    control = 1'b1;
                    check("wr_ready_pause", 32'(ready), 32'(exp_rdy));
                end
            end
            @(negedge clk);
            control = 1'b0;
            valid   = 1'b1;
            wrD     = d[i];
            last    = is_last && (i == 0);
            check("wr_ready_bit", 32'(ready), 32'(exp_rdy));
        end
    endtask

    task automatic do_write(input logic [1:0] id, input int addr, input logic [15:0] words[$],
                            input bit burst, input int pause_at);
        int  k;
        bit  hit;
        k   = words.size();
        hit = (id == SID);
        send_frame(id, 1'b0, burst, addr);
        check("wr_ready_after_frame", 32'(ready), 32'(hit));
        for (int i = 0; i < k; i++) begin
            write_word(words[i], burst && (i == k - 1), (i == 0) ? pause_at : -1, hit);
        end
        @(negedge clk);
        valid = 1'b0;
        last  = 1'b0;
        check("wr_ready_fall", 32'(ready), 32'd0);
        if (hit) begin
            for (int i = 0; i < k; i++) begin
                model_mem[(addr + i) % DEPTH] = words[i];
            end
        end
    endtask

    task automatic do_read(input int addr, input int k, input bit burst, input int lpos);
        for (int i = 0; i < k; i++) begin
            sb_q.push_back(model_mem[(addr + i) % DEPTH]);
        end
        rd_active = 1'b1;
        send_frame(SID, 1'b1, burst, addr);
        check("rd_ready_load_low", 32'(ready), 32'd0);
        for (int c = 0; c < 16 * k; c++) begin
            @(negedge clk);
            last = burst && (c == 16 * (k - 1) + lpos);
            check("rd_ready_tx", 32'(ready), 32'd1);
        end
        @(negedge clk);
        last = 1'b0;
        check("rd_ready_end", 32'(ready), 32'd0);
        rd_active = 1'b0;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        control    = 1'b0;
        wrD        = 1'b0;
        valid      = 1'b0;
        last       = 1'b0;
        rd_active  = 1'b0;
        mon_ignore = 1'b0;

        #3;
        check("reset_ready", 32'(ready), 32'd0);
        check("reset_rD", 32'(rD), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Single write then single read of addr 13
        r_words = {16'hA5C3};
        do_write(SID, 13, r_words, 1'b0, -1);
        do_read(13, 1, 1'b0, 0);

        // Burst write across the top of memory, read back as a burst
        r_words = {16'h0001, 16'h0002, 16'h0003};
        do_write(SID, 4095, r_words, 1'b1, -1);
        do_read(4095, 3, 1'b1, 9);
        do_read(0, 1, 1'b0, 0);

        // Frame for another slave: data phase ignored, mem[13] untouched
        r_words = {16'hFFFF};
        do_write(2'b10, 13, r_words, 1'b0, -1);
        do_read(13, 1, 1'b0, 0);

        // Paused write
        r_words = {16'h3C96};
        do_write(SID, 100, r_words, 1'b0, 8);
        do_read(100, 1, 1'b0, 0);

        // Reset in the middle of a read word (MSB first, 8th bit shown is bit 8 = 1)
        mon_ignore = 1'b1;
        send_frame(SID, 1'b1, 1'b0, 13);
        repeat (8) @(negedge clk);
        check("mid_read_ready", 32'(ready), 32'd1);
        check("mid_read_rD", 32'(rD), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_ready", 32'(ready), 32'd0);
        check("async_rst_rD", 32'(rD), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mon_ignore = 1'b0;
        do_read(13, 1, 1'b0, 0);

        // Randomized write / read-back pairs
        for (int t = 0; t < 12; t++) begin
            r_addr  = int'($urandom_range(0, DEPTH - 1));
            r_k     = int'($urandom_range(1, 3));
            r_burst = (r_k > 1) ? 1'b1 : 1'($urandom_range(0, 1));
            r_words = {};
            for (int i = 0; i < r_k; i++) begin
                r_words.push_back(16'($urandom));
            end
            do_write(SID, r_addr, r_words, r_burst,
                     (t % 3 == 0) ? int'($urandom_range(1, 14)) : -1);
            do_read(r_addr, r_k, r_burst, int'($urandom_range(0, 15)));
        end

        repeat (2) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
